// File: rtl/goertzel_pkg.sv
// -----------------------------------------------------------------------------
// goertzel_pkg
// Shared types and helpers for the Goertzel power detector.
//   det_state_t   : tone-decision FSM states
//   DEFAULT_SHIFT : default right shift applied to the 64-bit block power
//   sat_shift()   : unsigned right shift, saturated to an out_w-bit range
// -----------------------------------------------------------------------------
package goertzel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        ACTIVE,
        RELEASE
    } det_state_t;

    localparam int unsigned DEFAULT_SHIFT = 35;

    // Returns power >> shift, clamped to all-ones of out_w bits when any bit at
    // or above out_w survives the shift. Upper result bits are always zero
    // for out_w < 64, so callers may simply truncate to out_w.
    function automatic logic [63:0] sat_shift(
        input logic [63:0] power,
        input int unsigned shift,
        input int unsigned out_w
    );
        logic [63:0] shifted;
        logic [63:0] limit;
        shifted = power >> shift;
        if (out_w >= 64) begin
            limit = '1;
        end else begin
            limit = (64'd1 << out_w) - 64'd1;
        end
        sat_shift = (shifted > limit) ? limit : shifted;
    endfunction

endpackage

// File: rtl/goertzel_power_scale.sv
// -----------------------------------------------------------------------------
// goertzel_power_scale
// Front end of the detector: finds the 0->1 edge of `ready`, captures `power`
// on that edge (E0) and registers the shifted/saturated value one clock later
// (E1).
//   clock, reset : system clock, asynchronous active-high reset
//   ready        : result-ready level from the Goertzel core
//   power        : 64-bit unsigned block power, sampled on the ready edge only
//   blk_v        : one-cycle pulse, `scaled` holds a new block result
//   scaled       : power >> SHIFT, saturated to OUT_W bits
// -----------------------------------------------------------------------------
module goertzel_power_scale
    import goertzel_pkg::*;
#(
    parameter int unsigned SHIFT = DEFAULT_SHIFT,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ready,
    input  logic [63:0]      power,
    output logic             blk_v,
    output logic [OUT_W-1:0] scaled
);

    logic             ready_dly_q, ready_dly_d;
    logic             new_blk_q,   new_blk_d;
    logic [63:0]      power_q,     power_d;
    logic             blk_v_q,     blk_v_d;
    logic [OUT_W-1:0] scaled_q,    scaled_d;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps a combinational block from becoming a latch.
    always_comb begin
        ready_dly_d = ready;
        new_blk_d   = ready & ~ready_dly_q;
        power_d     = power_q;
        if (new_blk_d) begin
            power_d = power;
        end

        blk_v_d  = new_blk_q;
        scaled_d = scaled_q;
        if (new_blk_q) begin
            scaled_d = OUT_W'(sat_shift(power_q, SHIFT, OUT_W));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Starts high so a `ready` already asserted when reset releases is
            // treated as a stale result, not a new block.
            ready_dly_q <= 1'b1;
            new_blk_q   <= 1'b0;
            power_q     <= '0;
            blk_v_q     <= 1'b0;
            scaled_q    <= '0;
        end else begin
            ready_dly_q <= ready_dly_d;
            new_blk_q   <= new_blk_d;
            power_q     <= power_d;
            blk_v_q     <= blk_v_d;
            scaled_q    <= scaled_d;
        end
    end

    assign blk_v  = blk_v_q;
    assign scaled = scaled_q;

endmodule

// File: rtl/goertzel_power_detector.sv
// -----------------------------------------------------------------------------
// goertzel_power_detector
// Per Goertzel block: scales the power, runs a hysteretic tone decision with
// multi-block confirmation, and offers one result downstream over valid/ack.
//   clock, reset   : system clock, asynchronous active-high reset
//   ready, power   : result stream from the Goertzel core (new block on 0->1)
//   threshold_on   : attack threshold on the scaled power (>=)
//   threshold_off  : release threshold on the scaled power (<)
//   result_ack     : downstream accepts the pending result
//   result_valid   : a result is pending
//   result_power   : scaled power of the pending result
//   detected       : tone-present decision
//   overrun        : sticky, a pending result was overwritten before its ack
//   block_count    : number of blocks received, wrapping at 16 bits
// -----------------------------------------------------------------------------
module goertzel_power_detector
    import goertzel_pkg::*;
#(
    parameter int unsigned SHIFT          = DEFAULT_SHIFT,
    parameter int unsigned OUT_W          = 32,
    parameter int unsigned CONFIRM_BLOCKS = 3,
    parameter int unsigned RELEASE_BLOCKS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ready,
    input  logic [63:0]      power,
    input  logic [OUT_W-1:0] threshold_on,
    input  logic [OUT_W-1:0] threshold_off,
    input  logic             result_ack,
    output logic             result_valid,
    output logic [OUT_W-1:0] result_power,
    output logic             detected,
    output logic             overrun,
    output logic [15:0]      block_count
);

    localparam logic [3:0] CONFIRM_N = 4'(CONFIRM_BLOCKS);
    localparam logic [3:0] RELEASE_N = 4'(RELEASE_BLOCKS);

    logic             blk_v;
    logic [OUT_W-1:0] scaled;

    goertzel_power_scale #(
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_scale (
        .clock  (clock),
        .reset  (reset),
        .ready  (ready),
        .power  (power),
        .blk_v  (blk_v),
        .scaled (scaled)
    );

    det_state_t       state_q,        state_d;
    logic [3:0]       cnt_q,          cnt_d;
    logic             result_valid_q, result_valid_d;
    logic [OUT_W-1:0] result_power_q, result_power_d;
    logic             overrun_q,      overrun_d;
    logic [15:0]      block_count_q,  block_count_d;

    logic       above_on;
    logic       below_off;
    logic [3:0] cnt_inc;

    assign above_on  = (scaled >= threshold_on);
    assign below_off = (scaled <  threshold_off);
    assign cnt_inc   = cnt_q + 4'd1;

    // Decision FSM: `cnt` is the length of the current run of blocks on the
    // far side of the active threshold; a single block on the near side
    // aborts the run and returns to the settled state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (blk_v) begin
            unique case (state_q)
                IDLE: begin
                    if (above_on) begin
                        cnt_d   = 4'd1;
                        state_d = (CONFIRM_N == 4'd1) ? ACTIVE : ATTACK;
                    end
                end
                ATTACK: begin
                    if (above_on) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CONFIRM_N) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
                ACTIVE: begin
                    if (below_off) begin
                        cnt_d   = 4'd1;
                        state_d = (RELEASE_N == 4'd1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (below_off) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == RELEASE_N) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = ACTIVE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Result handshake. An ack retires the pending result; a block landing on
    // the same edge simply replaces it, so the new-block branch comes last.
    always_comb begin
        result_valid_d = result_valid_q;
        result_power_d = result_power_q;
        overrun_d      = overrun_q;
        block_count_d  = block_count_q;

        if (result_valid_q && result_ack) begin
            result_valid_d = 1'b0;
        end
        if (blk_v) begin
            result_valid_d = 1'b1;
            result_power_d = scaled;
            block_count_d  = block_count_q + 16'd1;
            if (result_valid_q && !result_ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            result_valid_q <= 1'b0;
            result_power_q <= '0;
            overrun_q      <= 1'b0;
            block_count_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_valid_q <= result_valid_d;
            result_power_q <= result_power_d;
            overrun_q      <= overrun_d;
            block_count_q  <= block_count_d;
        end
    end

    assign result_valid = result_valid_q;
    assign result_power = result_power_q;
    assign detected     = (state_q == ACTIVE) || (state_q == RELEASE);
    assign overrun      = overrun_q;
    assign block_count  = block_count_q;

endmodule
